dcache_miss_controller: RTL and testbench
=========================================

// Module: dcache_miss_controller
// PURPOSE
// - Sequences data-cache miss handling: dirty-victim writeback, then line refill from main memory, then tag install.
// - Sits beside the cache arrays at the memory stage.
// - Drives CacheStall into the hazard unit, which freezes F/D/E/M and flushes W while a miss is serviced.
// - Policy: write-back, write-allocate. The block is a single controller; arrays and tag compare live outside it.
// PARAMETERS
// ADDR_WIDTH      32  byte-address width
// WORDS_PER_LINE  4   32-bit words per cache line; power of two, >=2
// PORTS
// clk          in   1                       clock; all state updates on rising edge
// rst          in   1                       asynchronous, active-high reset
// ReqValidM    in   1                       load/store present in memory stage
// ReqAddrM     in   ADDR_WIDTH              byte address of that access
// HitM         in   1                       tag compare hit (valid & tag match), from tag array
// VictimDirty  in   1                       indexed line is valid and dirty
// VictimAddr   in   ADDR_WIDTH              line-aligned base address of the indexed (victim) line
// MemReq       out  1                       main-memory word request
// MemWrite     out  1                       1 = write beat (writeback), 0 = read beat (refill)
// MemAddr      out  ADDR_WIDTH              word address of current beat
// MemAck       in   1                       beat complete; read data valid this cycle
// LineBeat     out  $clog2(WORDS_PER_LINE)  word index into data array for current beat
// FillWe       out  1                       write memory read data into data array at LineBeat
// TagWe        out  1                       install tag of MissAddr, valid=1, dirty=0
// CacheStall   out  1                       freeze pipeline
// BEHAVIOUR
// - States: IDLE, WRITEBACK, REFILL, INSTALL.
// - Reset (async, immediate): state=IDLE, beat=0, MissAddr/VictimBase=0.
//   All outputs then read 0, except CacheStall, which follows the combinational IDLE rule below.
// - OFF = $clog2(WORDS_PER_LINE)+2. Line base = {addr[ADDR_WIDTH-1:OFF], OFF'b0}.
// - IDLE:
//   - CacheStall = ReqValidM & ~HitM, combinational, same cycle as detection.
//   - On a miss, latch MissAddr = line base of ReqAddrM and VictimBase = VictimAddr; beat=0.
//   - Next state = WRITEBACK if VictimDirty, else REFILL.
// - WRITEBACK:
//   - MemReq=1, MemWrite=1, MemAddr = VictimBase + 4*beat, LineBeat = beat (array read port supplies data).
//   - On MemAck: beat++. Ack on the last beat -> beat=0, go to REFILL.
// - REFILL:
//   - MemReq=1, MemWrite=0, MemAddr = MissAddr + 4*beat, LineBeat = beat, FillWe = MemAck.
//   - On MemAck: beat++. Ack on the last beat -> go to INSTALL.
// - INSTALL: one cycle; TagWe=1; then IDLE. The access re-looks-up next cycle and hits.
// - CacheStall=1 in every non-IDLE state.
// - Handshake:
//   - MemReq, MemWrite and MemAddr stay stable until MemAck; one beat per ack.
//   - MemAck while MemReq=0 is ignored.
//   - Arbitrary ack wait states are legal; no timeout.
// - Beat counter wraps at WORDS_PER_LINE; last beat = WORDS_PER_LINE-1.
// - ReqValidM, ReqAddrM, HitM and VictimDirty are ignored outside IDLE (pipeline is frozen; latched copies are used).
// - Latency with zero-wait memory:
//   - clean miss: stall for WORDS_PER_LINE+2 cycles;
//   - dirty miss: stall for 2*WORDS_PER_LINE+2 cycles;
//   - hit: 0.
// - Reset mid-miss: MemReq drops asynchronously and the partial line is abandoned.
//   The tag is never installed, so the line stays invalid or unchanged.
// - Back-to-back misses: a new miss is detectable in the first IDLE cycle after INSTALL.
// TESTING
// - Reset: assert rst mid-cycle -> MemReq/FillWe/TagWe/LineBeat=0 immediately; with ReqValidM=0, CacheStall=0.
// - Hit: ReqValidM=1, HitM=1 -> CacheStall=0, MemReq=0 for all cycles.
// - Clean miss: ReqAddrM=0x1234, HitM=0, VictimDirty=0, MemAck held 1.
//   -> MemAddr 0x1230,0x1234,0x1238,0x123C with FillWe=1 and LineBeat 0..3; TagWe=1 one cycle; CacheStall high exactly 6 cycles.
// - Dirty miss: VictimAddr=0x8230, VictimDirty=1.
//   -> 4 write beats 0x8230..0x823C (MemWrite=1), then 4 read beats 0x1230..0x123C; CacheStall high 10 cycles.
// - Wait states: MemAck low 3 cycles per beat -> MemAddr/MemReq stable while waiting; each beat advances only on ack; FillWe only on ack cycles.
// - Abort: rst during REFILL beat 2 -> IDLE, TagWe never pulses; a later stray MemAck with MemReq=0 causes no change.

Source files
------------

// File: rtl/dcache_miss_controller.sv
// Data-cache miss controller.
// Services a write-back, write-allocate miss in three steps: write the dirty
// victim line back, refill the missing line from main memory, then install
// its tag. CacheStall holds the pipeline frozen until the line is present.
module dcache_miss_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ReqValidM,
  input  logic [ADDR_WIDTH-1:0]             ReqAddrM,
  input  logic                              HitM,
  input  logic                              VictimDirty,
  input  logic [ADDR_WIDTH-1:0]             VictimAddr,
  output logic                              MemReq,
  output logic                              MemWrite,
  output logic [ADDR_WIDTH-1:0]             MemAddr,
  input  logic                              MemAck,
  output logic [$clog2(WORDS_PER_LINE)-1:0] LineBeat,
  output logic                              FillWe,
  output logic                              TagWe,
  output logic                              CacheStall
);

  localparam int BW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    INSTALL
  } state_t;

  state_t                  state, stateNext;
  logic [BW-1:0]           beat, beatNext;
  logic [ADDR_WIDTH-1:0]   missAddr, missAddrNext;
  logic [ADDR_WIDTH-1:0]   victimBase, victimBaseNext;
  logic [ADDR_WIDTH-1:0]   beatOff;
  logic                    miss;

  // Byte offset of the current word within the line.
  assign beatOff = {{(ADDR_WIDTH-OFF){1'b0}}, beat, 2'b00};

  // A miss is only recognised while the controller is idle.
  assign miss = ReqValidM & ~HitM;

  // State, beat counter and latched miss/victim line addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      missAddr   <= '0;
      victimBase <= '0;
    end else begin
      state      <= stateNext;
      beat       <= beatNext;
      missAddr   <= missAddrNext;
      victimBase <= victimBaseNext;
    end
  end

  // Next-state logic and memory/array strobes for the current phase.
  always_comb begin
    stateNext      = state;
    beatNext       = beat;
    missAddrNext   = missAddr;
    victimBaseNext = victimBase;
    MemReq         = 1'b0;
    MemWrite       = 1'b0;
    MemAddr        = '0;
    LineBeat       = '0;
    FillWe         = 1'b0;
    TagWe          = 1'b0;
    CacheStall     = 1'b1;

    unique case (state)
      IDLE: begin
        CacheStall = miss;
        if (miss) begin
          missAddrNext   = {ReqAddrM[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          victimBaseNext = VictimAddr;
          beatNext       = '0;
          stateNext      = VictimDirty ? WRITEBACK : REFILL;
        end
      end

      WRITEBACK: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        MemAddr  = victimBase + beatOff;
        LineBeat = beat;
        if (MemAck) begin
          if (beat == LAST_BEAT) begin
            beatNext  = '0;
            stateNext = REFILL;
          end else begin
            beatNext = beat + BW'(1);
          end
        end
      end

      REFILL: begin
        MemReq   = 1'b1;
        MemAddr  = missAddr + beatOff;
        LineBeat = beat;
        FillWe   = MemAck;
        if (MemAck) begin
          beatNext = beat + BW'(1);
          if (beat == LAST_BEAT) begin
            stateNext = INSTALL;
          end
        end
      end

      INSTALL: begin
        TagWe     = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Testbench for dcache_miss_controller.
// A transaction-level model (a queue of pending memory beats plus an
// install flag) predicts every output each cycle; directed scenarios pin
// the model with literal addresses, beat counts and stall lengths.
module tb_dcache_miss_controller;

  localparam int AW  = 32;
  localparam int WPL = 4;
  localparam int BW  = $clog2(WPL);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ReqValidM = 1'b0;
  logic [AW-1:0] ReqAddrM = '0;
  logic          HitM = 1'b0;
  logic          VictimDirty = 1'b0;
  logic [AW-1:0] VictimAddr = '0;
  logic          MemReq;
  logic          MemWrite;
  logic [AW-1:0] MemAddr;
  logic          MemAck = 1'b0;
  logic [BW-1:0] LineBeat;
  logic          FillWe;
  logic          TagWe;
  logic          CacheStall;

  dcache_miss_controller #(
    .ADDR_WIDTH    (AW),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ReqValidM  (ReqValidM),
    .ReqAddrM   (ReqAddrM),
    .HitM       (HitM),
    .VictimDirty(VictimDirty),
    .VictimAddr (VictimAddr),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .LineBeat   (LineBeat),
    .FillWe     (FillWe),
    .TagWe      (TagWe),
    .CacheStall (CacheStall)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
  } beat_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    bit            fill;
    int            lb;
  } logEntry_t;

  beat_t     mq[$];
  bit        installPending = 1'b0;
  logEntry_t beatLog[$];

  int checks = 0;
  int errors = 0;
  int stallCount = 0;
  int fillCount = 0;
  int tagWeCount = 0;
  int reqCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic h, input logic d,
                               input logic [AW-1:0] a, input logic [AW-1:0] va,
                               input logic ack);
    ReqValidM   = v;
    HitM        = h;
    VictimDirty = d;
    ReqAddrM    = a;
    VictimAddr  = va;
    MemAck      = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    bit            expReq, expWr, expFill, expTag, expStall;
    logic [AW-1:0] expAddr;
    logic [AW-1:0] lineBase;
    if (rst) begin
      checkOutput("rst_memreq", 32'(MemReq), 32'd0);
      checkOutput("rst_fillwe", 32'(FillWe), 32'd0);
      checkOutput("rst_tagwe", 32'(TagWe), 32'd0);
      checkOutput("rst_linebeat", 32'(LineBeat), 32'd0);
      checkOutput("rst_stall", 32'(CacheStall), 32'(ReqValidM & ~HitM));
      mq.delete();
      installPending = 1'b0;
    end else begin
      expReq = 0; expWr = 0; expFill = 0; expTag = 0; expAddr = '0;
      if (installPending) begin
        expTag   = 1;
        expStall = 1;
      end else if (mq.size() > 0) begin
        expReq   = 1;
        expWr    = mq[0].wr;
        expAddr  = mq[0].addr;
        expFill  = ~mq[0].wr & MemAck;
        expStall = 1;
      end else begin
        expStall = ReqValidM & ~HitM;
      end

      checkOutput("memreq", 32'(MemReq), 32'(expReq));
      checkOutput("fillwe", 32'(FillWe), 32'(expFill));
      checkOutput("tagwe", 32'(TagWe), 32'(expTag));
      checkOutput("stall", 32'(CacheStall), 32'(expStall));
      if (expReq) begin
        checkOutput("memwrite", 32'(MemWrite), 32'(expWr));
        checkOutput("memaddr", MemAddr, expAddr);
        checkOutput("linebeat", 32'(LineBeat), 32'(expAddr[BW+1:2]));
      end

      if (CacheStall) stallCount++;
      if (FillWe) fillCount++;
      if (TagWe) tagWeCount++;
      if (MemReq) reqCount++;
      if (MemReq && MemAck)
        beatLog.push_back('{wr: MemWrite, addr: MemAddr, fill: FillWe, lb: int'(LineBeat)});

      if (installPending) begin
        installPending = 1'b0;
      end else if (mq.size() > 0) begin
        if (MemAck) begin
          void'(mq.pop_front());
          if (mq.size() == 0) installPending = 1'b1;
        end
      end else if (ReqValidM && !HitM) begin
        lineBase = ReqAddrM & ~AW'(WPL * 4 - 1);
        if (VictimDirty)
          for (int i = 0; i < WPL; i++) mq.push_back('{wr: 1'b1, addr: VictimAddr + AW'(4 * i)});
        for (int i = 0; i < WPL; i++) mq.push_back('{wr: 1'b0, addr: lineBase + AW'(4 * i)});
      end
    end
  end

  // One complete miss with a fixed number of ack wait states per beat.
  task automatic runMiss(input string tag, input bit dirty, input logic [AW-1:0] addr,
                         input logic [AW-1:0] victim, input int waits);
    int n, tag0;
    logic [AW-1:0] base;
    n    = dirty ? 2 * WPL : WPL;
    base = addr & ~AW'(WPL * 4 - 1);
    beatLog.delete();
    stallCount = 0;
    fillCount  = 0;
    tag0       = tagWeCount;
    applyStimulus(1'b1, 1'b0, dirty, addr, victim, waits == 0);
    tick();
    HitM = 1'b1;
    for (int b = 0; b < n; b++) begin
      repeat (waits) begin
        MemAck = 1'b0;
        tick();
      end
      MemAck = 1'b1;
      tick();
    end
    MemAck = 1'b0;
    tick();
    repeat (3) tick();
    ReqValidM = 1'b0;
    tick();

    checkOutput({tag, "_beats"}, 32'(beatLog.size()), 32'(n));
    checkOutput({tag, "_stall"}, 32'(stallCount), 32'(2 + n * (waits + 1)));
    checkOutput({tag, "_fills"}, 32'(fillCount), 32'(WPL));
    checkOutput({tag, "_tagwe"}, 32'(tagWeCount - tag0), 32'd1);
    for (int i = 0; i < beatLog.size() && i < n; i++) begin
      bit wb;
      int k;
      wb = dirty && (i < WPL);
      k  = i % WPL;
      checkOutput({tag, "_wr"}, 32'(beatLog[i].wr), 32'(wb));
      checkOutput({tag, "_addr"}, beatLog[i].addr, (wb ? victim : base) + AW'(4 * k));
      checkOutput({tag, "_fill"}, 32'(beatLog[i].fill), 32'(!wb));
      checkOutput({tag, "_lb"}, 32'(beatLog[i].lb), 32'(k));
    end
  endtask

  initial begin
    int tag0, req0;

    // Reset asserted mid-cycle with no request present.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_memreq", 32'(MemReq), 32'd0);
    checkOutput("reset_fillwe", 32'(FillWe), 32'd0);
    checkOutput("reset_tagwe", 32'(TagWe), 32'd0);
    checkOutput("reset_linebeat", 32'(LineBeat), 32'd0);
    checkOutput("reset_stall", 32'(CacheStall), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Hits never stall or touch memory.
    stallCount = 0;
    reqCount   = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_5678, 32'h0000_9990, 1'b1);
    repeat (6) tick();
    ReqValidM = 1'b0;
    tick();
    checkOutput("hit_stall", 32'(stallCount), 32'd0);
    checkOutput("hit_memreq", 32'(reqCount), 32'd0);

    runMiss("clean", 1'b0, 32'h0000_1234, 32'h0000_8230, 0);
    runMiss("dirty", 1'b1, 32'h0000_1234, 32'h0000_8230, 0);
    runMiss("wait", 1'b0, 32'h0000_1234, 32'h0000_8230, 3);
    runMiss("waitd", 1'b1, 32'hABCD_EF5C, 32'h0040_0010, 2);

    // Reset during refill beat 2 abandons the line without a tag install.
    tag0 = tagWeCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_8230, 1'b1);
    tick();
    HitM = 1'b1;
    tick();
    tick();
    #1;
    checkOutput("abort_beat2_lb", 32'(LineBeat), 32'd2);
    checkOutput("abort_beat2_addr", MemAddr, 32'h0000_1238);
    ReqValidM = 1'b0;
    MemAck    = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("abort_memreq", 32'(MemReq), 32'd0);
    checkOutput("abort_fillwe", 32'(FillWe), 32'd0);
    checkOutput("abort_stall", 32'(CacheStall), 32'd0);
    tick();
    rst = 1'b0;
    req0 = reqCount;
    MemAck = 1'b1;
    repeat (4) tick();
    MemAck = 1'b0;
    tick();
    checkOutput("abort_tagwe", 32'(tagWeCount - tag0), 32'd0);
    checkOutput("stray_ack_memreq", 32'(reqCount - req0), 32'd0);

    // Randomised traffic with occasional resets, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 1, $urandom,
                    $urandom & ~AW'(WPL * 4 - 1), $urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
